stream_fifo_thr: RTL
====================

# stream_fifo_thr

Parametrised successor to the team's stream FIFO: a valid/ready FIFO with arbitrary (non-power-of-two) depth, an occupancy counter, programmable almost-full/almost-empty flags and an optional zero-latency bypass. It sits between pipeline stages that need early back-pressure warning. Examples are the fetch-to-decode queue and the LSU request buffers, where producers throttle on `afull_o` rather than on `enq_rdy_o`.

## Interface
- `Depth`, 8, number of entries; any integer >= 2.
- `WordWidth`, 64, payload width in bits.
- `AfullThresh`, Depth-2, `afull_o` asserts when count >= this value; legal range 1..Depth.
- `AemptyThresh`, 1, `aempty_o` asserts when count <= this value; legal range 0..Depth-1.
- `CntWidth`, derived, $clog2(Depth+1); not to be overridden.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `enq_vld_i`  in  1  producer valid.
- `enq_payload_i`  in  WordWidth  producer data.
- `enq_rdy_o`  out  1  FIFO can accept.
- `deq_vld_o`  out  1  head entry valid.
- `deq_payload_o`  out  WordWidth  head entry data.
- `deq_rdy_i`  in  1  consumer ready.
- `flush_i`  in  1  synchronous discard of all contents.
- `count_o`  out  CntWidth  current occupancy, 0..Depth.
- `afull_o`  out  1  almost-full flag.
- `aempty_o`  out  1  almost-empty flag.

## Operation
- Handshake rules:
  - enq fire = `enq_vld_i` & `enq_rdy_o`.
  - deq fire = `deq_vld_o` & `deq_rdy_i`.
  - `enq_rdy_o` = (count != Depth) & ~`flush_i`. It does not depend on a same-cycle pop, so there is no full-and-pop pass-through.
  - `deq_vld_o` = (count != 0) & ~`flush_i`, or the bypass condition (see Configuration).
- Storage is a Depth x WordWidth register array with write pointer `wp` and read pointer `rp`, each 0..Depth-1.
  - A pointer increments on its fire event.
  - At Depth-1 it wraps to 0 explicitly; there is no modulo-2^n aliasing.
- `deq_payload_o` = mem[`rp`] (first-word-fall-through). It is don't-care while `deq_vld_o` = 0.
- Count update: +1 on enq fire only, -1 on deq fire only, unchanged on both or neither. Count never exceeds Depth and never goes below 0.
- `afull_o` and `aempty_o` are combinational compares of the registered count only; they do not depend on inputs.
- Flush takes priority over all other events:
  - In the flush cycle, `wp`, `rp` and count are set to 0 at the next edge.
  - Fires are suppressed because of the ready/valid gating above.
  - Storage contents are not cleared.
- Reset: `wp` = `rp` = count = 0. Outputs after reset:
  - `enq_rdy_o` = 1
  - `deq_vld_o` = 0
  - `count_o` = 0
  - `afull_o` = 0
  - `aempty_o` = 1

## Timing
- Enqueue-to-dequeue latency is 1 cycle. A word enqueued at edge t is visible on `deq_vld_o`/`deq_payload_o` after edge t+1 (bypass excluded).
- Throughput is 1 push and 1 pop per cycle sustained whenever 0 < count < Depth.
- `count_o` and the flags reflect the state after the previous edge, so the flags lag fires by one cycle.
- Full boundary: with count = Depth, `enq_rdy_o` = 0 even if `deq_rdy_i` = 1; after a pop, `enq_rdy_o` = 1 in the following cycle.
- Empty boundary: with count = 0 and no bypass, `deq_vld_o` = 0 regardless of `enq_vld_i`.
- Reset asserted mid-stream: state is cleared at that edge. In-flight fires in the reset cycle are discarded; the outputs in that cycle are don't-care.

## Configuration
- Macro: `STREAM_FIFO_THR_BYPASS_EN`.
- Defined:
  - When count = 0, ~`flush_i` and `enq_vld_i` = 1: `deq_vld_o` = 1 and `deq_payload_o` = `enq_payload_i` in the same cycle.
  - If `deq_rdy_i` = 1 in that cycle, the word passes through with no write, no pointer move and count unchanged.
  - Otherwise the word is written normally.
- Undefined: no combinational path from the enq inputs to the deq outputs; latency is as in Timing.

## Structure
- Package `stream_fifo_pkg`:
  - default Depth/WordWidth constants;
  - width-helper function `cnt_width(depth)` returning $clog2(depth+1);
  - elaboration-time parameter-legality checks for the thresholds.
- Sub-module `stream_fifo_wrap_ptr`:
  - parameters `Depth`;
  - inputs `clk`, `rst`, `inc_i`, `clr_i`; output `ptr_o`;
  - wrap-at-Depth-1 counter, instantiated twice (`wp`, `rp`).
- Top-level holds the storage array, the count register, the flag compares and the bypass logic.

## Test plan
- Depth=5, fill: push 5 words (0x11..0x55) with `deq_rdy_i`=0.
  - `enq_rdy_o` drops after the 5th fire; `count_o`=5.
  - `afull_o` is 1 from count 3 (threshold default 3).
- Wrap: with Depth=5, push/pop 12 words with `deq_rdy_i`=1 and `enq_vld_i`=1.
  - Output order is 0..11.
  - count stays 1 in steady state; no pointer alias.
- Full with pop: at count=5, `enq_vld_i`=1 and `deq_rdy_i`=1.
  - Only the pop fires; next cycle count=4 and `enq_rdy_o`=1.
- Flush at count=3 with `enq_vld_i`=1 in the same cycle.
  - No enqueue; next cycle count=0, `deq_vld_o`=0, `aempty_o`=1.
- Bypass (macro defined), empty FIFO: `enq_vld_i`=1 with 0xAB, `deq_rdy_i`=1.
  - Same-cycle `deq_payload_o`=0xAB; count stays 0.
- Bypass (macro undefined), same stimulus:
  - `deq_vld_o`=0 in that cycle;
  - 0xAB appears the next cycle with count=1.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// Shared defaults, width helper and parameter-legality check for the threshold stream FIFO.
package stream_fifo_pkg;

    localparam int DefaultDepth     = 8;
    localparam int DefaultWordWidth = 64;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit thresh_legal(input int depth, input int afull, input int aempty);
        return (depth >= 2) && (afull >= 1) && (afull <= depth) &&
               (aempty >= 0) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/stream_fifo_thr_if.sv
// Enqueue/dequeue handshake, flush and status bundle of the threshold stream FIFO.
interface stream_fifo_thr_if
    import stream_fifo_pkg::*;
#(
    parameter int Depth     = DefaultDepth,
    parameter int WordWidth = DefaultWordWidth
);
    localparam int CntWidth = cnt_width(Depth);

    logic                 enq_vld_i;
    logic [WordWidth-1:0] enq_payload_i;
    logic                 enq_rdy_o;
    logic                 deq_vld_o;
    logic [WordWidth-1:0] deq_payload_o;
    logic                 deq_rdy_i;
    logic                 flush_i;
    logic [CntWidth-1:0]  count_o;
    logic                 afull_o;
    logic                 aempty_o;

    modport slave (
        input  enq_vld_i, enq_payload_i, deq_rdy_i, flush_i,
        output enq_rdy_o, deq_vld_o, deq_payload_o, count_o, afull_o, aempty_o
    );

    modport master (
        output enq_vld_i, enq_payload_i, deq_rdy_i, flush_i,
        input  enq_rdy_o, deq_vld_o, deq_payload_o, count_o, afull_o, aempty_o
    );
endinterface

// File: rtl/stream_fifo_wrap_ptr.sv
// Pointer counting 0..Depth-1 with an explicit wrap, so non-power-of-two depths never alias.
module stream_fifo_wrap_ptr #(
    parameter int Depth = 8,
    localparam int PtrWidth = $clog2(Depth)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_i,
    input  logic                clr_i,
    output logic [PtrWidth-1:0] ptr_o
);
    logic [PtrWidth-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PtrWidth'(Depth - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/stream_fifo_thr.sv
// Valid/ready FIFO with occupancy count and almost-full/empty flags.
// Optional same-cycle bypass when empty: define STREAM_FIFO_THR_BYPASS_EN.
module stream_fifo_thr
    import stream_fifo_pkg::*;
#(
    parameter int Depth        = DefaultDepth,
    parameter int WordWidth    = DefaultWordWidth,
    parameter int AfullThresh  = Depth - 2,
    parameter int AemptyThresh = 1
) (
    input  logic               clk,
    input  logic               rst,
    stream_fifo_thr_if.slave   bus
);
    localparam int CntWidth = cnt_width(Depth);
    localparam int PtrWidth = $clog2(Depth);

    if (!thresh_legal(Depth, AfullThresh, AemptyThresh)) begin : g_bad_params
        $error("stream_fifo_thr: illegal Depth/threshold combination");
    end

    logic [WordWidth-1:0] mem_q [Depth];
    logic [CntWidth-1:0]  count_q, count_d;
    logic [PtrWidth-1:0]  wp, rp;
    logic                 empty, full, enq_fire, deq_fire, byp_pass, wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntWidth'(Depth));

    assign bus.enq_rdy_o = ~full & ~bus.flush_i;
    assign enq_fire      = bus.enq_vld_i & bus.enq_rdy_o;
    assign deq_fire      = bus.deq_vld_o & bus.deq_rdy_i;

    always_comb begin
        bus.deq_vld_o     = ~empty & ~bus.flush_i;
        bus.deq_payload_o = mem_q[rp];
`ifdef STREAM_FIFO_THR_BYPASS_EN
        if (empty & ~bus.flush_i & bus.enq_vld_i) begin
            bus.deq_vld_o     = 1'b1;
            bus.deq_payload_o = bus.enq_payload_i;
        end
`endif
    end

`ifdef STREAM_FIFO_THR_BYPASS_EN
    // A word consumed in its arrival cycle never touches storage or pointers.
    assign byp_pass = empty & ~bus.flush_i & bus.enq_vld_i & bus.deq_rdy_i;
`else
    assign byp_pass = 1'b0;
`endif

    assign wr_en = enq_fire & ~byp_pass;
    assign rd_en = deq_fire & ~byp_pass;

    stream_fifo_wrap_ptr #(.Depth(Depth)) u_wp (
        .clk   (clk),
        .rst   (rst),
        .inc_i (wr_en),
        .clr_i (bus.flush_i),
        .ptr_o (wp)
    );

    stream_fifo_wrap_ptr #(.Depth(Depth)) u_rp (
        .clk   (clk),
        .rst   (rst),
        .inc_i (rd_en),
        .clr_i (bus.flush_i),
        .ptr_o (rp)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wp] <= bus.enq_payload_i;
    end

    always_comb begin
        count_d = count_q;
        if (bus.flush_i) begin
            count_d = '0;
        end else if (wr_en & ~rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en & ~wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign bus.count_o  = count_q;
    assign bus.afull_o  = (count_q >= CntWidth'(AfullThresh));
    assign bus.aempty_o = (count_q <= CntWidth'(AemptyThresh));
endmodule
